// File: rtl/noc_msg_parser_pkg.sv
// Shared definitions for the NoC message parser: state encodings and the OpenPiton
// header field positions (mirroring the define.tmp.h NoC slice macros).
package noc_msg_parser_pkg;

  localparam int NOC_DATA_WIDTH = 64;
  localparam int PHY_ADDR_WIDTH = 40;
  localparam int HDR_FLITS      = 3;
  localparam int CNT_W          = 5;

  localparam logic [2:0] PARSER_HDR0    = 3'd0;
  localparam logic [2:0] PARSER_HDR1    = 3'd1;
  localparam logic [2:0] PARSER_HDR2    = 3'd2;
  localparam logic [2:0] PARSER_PAYLOAD = 3'd3;
  localparam logic [2:0] PARSER_OUT     = 3'd4;

  // Flit 0
  localparam int MSG_LENGTH_LO = 22;
  localparam int MSG_TYPE_HI   = 21;
  localparam int MSG_TYPE_LO   = 14;
  localparam int MSG_MSHRID_HI = 13;
  localparam int MSG_MSHRID_LO = 6;
  // Flit 1
  localparam int MSG_ADDR_HI   = PHY_ADDR_WIDTH - 1;
  localparam int MSG_ADDR_LO   = 0;
  // Flit 2
  localparam int MSG_SRC_CHIPID_HI = 63;
  localparam int MSG_SRC_CHIPID_LO = 50;
  localparam int MSG_SRC_X_HI      = 49;
  localparam int MSG_SRC_X_LO      = 42;
  localparam int MSG_SRC_Y_HI      = 41;
  localparam int MSG_SRC_Y_LO      = 34;
  localparam int MSG_SRC_FBITS_HI  = 33;
  localparam int MSG_SRC_FBITS_LO  = 30;

  // Number of payload flits that will actually be stored for a given length.
  function automatic logic [3:0] payload_cnt_f(input logic [3:0] len, input logic [3:0] max_pl);
    if (len < 4'd2)
      return 4'd0;
    else if ((len - 4'd2) > max_pl)
      return max_pl;
    else
      return len - 4'd2;
  endfunction

endpackage

// File: rtl/noc_msg_parser_payload_gather.sv
// Payload slot bank: MAX_PAYLOAD flit-wide registers with an indexed write and a
// synchronous clear that takes priority over the write.
module noc_payload_gather
  import noc_msg_parser_pkg::*;
#(
  parameter int MAX_PAYLOAD = 6,
  parameter int W           = NOC_DATA_WIDTH,
  parameter int IDX_W       = CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [W-1:0]             wr_data,
  output logic [MAX_PAYLOAD*W-1:0] payload
);

  genvar gi;
  generate
    for (gi = 0; gi < MAX_PAYLOAD; gi++) begin : g_slot
      logic [W-1:0] slot_q;
      logic [W-1:0] slot_d;

      always_comb begin
        slot_d = slot_q;
        if (clr)
          slot_d = '0;
        else if (wr_en && (wr_idx == IDX_W'(gi)))
          slot_d = wr_data;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          slot_q <= '0;
        else
          slot_q <= slot_d;
      end

      assign payload[gi*W +: W] = slot_q;
    end
  endgenerate

endmodule

// File: rtl/noc_msg_parser.sv
// Parses an OpenPiton NoC message (3 header flits + payload) into one wide request.
// Optional length checking and the req_err port are enabled by MSG_PARSER_ERR_EN.
module noc_msg_parser
  import noc_msg_parser_pkg::*;
#(
  parameter int MAX_PAYLOAD = 6
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NOC_DATA_WIDTH-1:0]             flit_in,
  input  logic                                  flit_valid,
  output logic                                  flit_ready,
  output logic                                  req_valid,
  input  logic                                  req_ready,
  output logic [7:0]                            req_type,
  output logic [7:0]                            req_mshrid,
  output logic [PHY_ADDR_WIDTH-1:0]             req_addr,
  output logic [13:0]                           req_src_chipid,
  output logic [7:0]                            req_src_x,
  output logic [7:0]                            req_src_y,
  output logic [3:0]                            req_src_fbits,
  output logic [3:0]                            req_payload_cnt,
  output logic [MAX_PAYLOAD*NOC_DATA_WIDTH-1:0] req_payload
`ifdef MSG_PARSER_ERR_EN
  ,
  output logic                                  req_err
`endif
);

  logic [2:0]                state_q, state_d;
  logic [CNT_W-1:0]          flit_cnt_q, flit_cnt_d;
  logic [3:0]                len_q, len_d;
  logic [7:0]                type_q, type_d;
  logic [7:0]                mshrid_q, mshrid_d;
  logic [PHY_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [13:0]               chipid_q, chipid_d;
  logic [7:0]                src_x_q, src_x_d;
  logic [7:0]                src_y_q, src_y_d;
  logic [3:0]                fbits_q, fbits_d;
  logic [3:0]                pcnt_q, pcnt_d;

  logic             flit_acc, req_acc;
  logic [3:0]       len_in;
  logic [CNT_W-1:0] pay_idx;
  logic             gather_clr, gather_wr;

  assign flit_ready = (state_q != PARSER_OUT);
  assign req_valid  = (state_q == PARSER_OUT);
  assign flit_acc   = flit_valid && flit_ready;
  assign req_acc    = req_valid && req_ready;
  assign len_in     = flit_in[MSG_LENGTH_LO +: 4];
  assign pay_idx    = flit_cnt_q - CNT_W'(HDR_FLITS);

  always_comb begin
    state_d    = state_q;
    flit_cnt_d = flit_cnt_q;
    len_d      = len_q;
    type_d     = type_q;
    mshrid_d   = mshrid_q;
    addr_d     = addr_q;
    chipid_d   = chipid_q;
    src_x_d    = src_x_q;
    src_y_d    = src_y_q;
    fbits_d    = fbits_q;
    pcnt_d     = pcnt_q;
    gather_clr = 1'b0;
    gather_wr  = 1'b0;
    case (state_q)
      PARSER_HDR0: if (flit_acc) begin
        type_d     = flit_in[MSG_TYPE_HI:MSG_TYPE_LO];
        mshrid_d   = flit_in[MSG_MSHRID_HI:MSG_MSHRID_LO];
        len_d      = len_in;
        pcnt_d     = payload_cnt_f(len_in, 4'(MAX_PAYLOAD));
        // A new message must never expose fields left over from the previous one.
        addr_d     = '0;
        chipid_d   = '0;
        src_x_d    = '0;
        src_y_d    = '0;
        fbits_d    = '0;
        gather_clr = 1'b1;
        flit_cnt_d = CNT_W'(1);
        state_d    = (len_in == 4'd0) ? PARSER_OUT : PARSER_HDR1;
      end
      PARSER_HDR1: if (flit_acc) begin
        addr_d     = flit_in[MSG_ADDR_HI:MSG_ADDR_LO];
        flit_cnt_d = CNT_W'(2);
        state_d    = (len_q == 4'd1) ? PARSER_OUT : PARSER_HDR2;
      end
      PARSER_HDR2: if (flit_acc) begin
        chipid_d   = flit_in[MSG_SRC_CHIPID_HI:MSG_SRC_CHIPID_LO];
        src_x_d    = flit_in[MSG_SRC_X_HI:MSG_SRC_X_LO];
        src_y_d    = flit_in[MSG_SRC_Y_HI:MSG_SRC_Y_LO];
        fbits_d    = flit_in[MSG_SRC_FBITS_HI:MSG_SRC_FBITS_LO];
        flit_cnt_d = CNT_W'(3);
        state_d    = (len_q == 4'd2) ? PARSER_OUT : PARSER_PAYLOAD;
      end
      PARSER_PAYLOAD: if (flit_acc) begin
        // Flits beyond the slot bank are drained but not stored.
        gather_wr  = (pay_idx < CNT_W'(MAX_PAYLOAD));
        flit_cnt_d = flit_cnt_q + CNT_W'(1);
        if (flit_cnt_q == {1'b0, len_q})
          state_d = PARSER_OUT;
      end
      PARSER_OUT: if (req_acc) begin
        state_d    = PARSER_HDR0;
        flit_cnt_d = '0;
      end
      default: state_d = PARSER_HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PARSER_HDR0;
      flit_cnt_q <= '0;
      len_q      <= '0;
      type_q     <= '0;
      mshrid_q   <= '0;
      addr_q     <= '0;
      chipid_q   <= '0;
      src_x_q    <= '0;
      src_y_q    <= '0;
      fbits_q    <= '0;
      pcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      flit_cnt_q <= flit_cnt_d;
      len_q      <= len_d;
      type_q     <= type_d;
      mshrid_q   <= mshrid_d;
      addr_q     <= addr_d;
      chipid_q   <= chipid_d;
      src_x_q    <= src_x_d;
      src_y_q    <= src_y_d;
      fbits_q    <= fbits_d;
      pcnt_q     <= pcnt_d;
    end
  end

  noc_payload_gather #(
    .MAX_PAYLOAD (MAX_PAYLOAD),
    .W           (NOC_DATA_WIDTH),
    .IDX_W       (CNT_W)
  ) u_gather (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (gather_clr),
    .wr_en   (gather_wr),
    .wr_idx  (pay_idx),
    .wr_data (flit_in),
    .payload (req_payload)
  );

  assign req_type        = type_q;
  assign req_mshrid      = mshrid_q;
  assign req_addr        = addr_q;
  assign req_src_chipid  = chipid_q;
  assign req_src_x       = src_x_q;
  assign req_src_y       = src_y_q;
  assign req_src_fbits   = fbits_q;
  assign req_payload_cnt = pcnt_q;

`ifdef MSG_PARSER_ERR_EN
  logic err_q, err_d;
  logic [3:0] len_final;

  // The length that governs this message: live flit on a single-flit message, latched otherwise.
  assign len_final = (state_q == PARSER_HDR0) ? len_in : len_q;

  always_comb begin
    err_d = err_q;
    if (req_acc)
      err_d = 1'b0;
    else if ((state_q != PARSER_OUT) && (state_d == PARSER_OUT))
      err_d = (len_final < 4'd2) || (int'(len_final) > 2 + MAX_PAYLOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else
      err_q <= err_d;
  end

  assign req_err = err_q;
`endif

endmodule
